// File: rtl/tx_queue.sv
// tx_queue: circular packet queue that presents one registered packet at a time to a serial encoder.
// Define TX_QUEUE_GAP_EN to hold GAP_CYCLES idle cycles after every packet; undefined, packets run back to back.
`ifndef PACKET_SIZE
`define PACKET_SIZE 8
`endif

module tx_queue #(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [`PACKET_SIZE-1:0] wr_data,
    input  logic                    wr_en,
    input  logic                    enc_done,
    output logic [`PACKET_SIZE-1:0] enc_data,
    output logic                    enc_valid,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
`ifdef TX_QUEUE_GAP_EN
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam int         CW      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
`endif

    logic [`PACKET_SIZE-1:0] mem_q [DEPTH];
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_next;
    logic [LW-1:0]           level_q, level_d;
    logic [1:0]              state_q, state_d;
    logic [`PACKET_SIZE-1:0] enc_data_q, enc_data_d;
    logic                    overflow_q, overflow_d;
    logic                    wr_accept;
    logic                    pop;
`ifdef TX_QUEUE_GAP_EN
    logic [CW-1:0]           gap_cnt_q, gap_cnt_d;
`endif

    // A full queue refuses writes even when the head is popped in the same cycle.
    assign full      = (level_q == LW'(DEPTH));
    assign empty     = (level_q == '0);
    assign wr_accept = wr_en && !full;
    assign pop       = (state_q == ST_SEND) && enc_done;
    assign rd_next   = rd_ptr_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        enc_data_d = enc_data_q;
        rd_ptr_d   = pop ? rd_next : rd_ptr_q;
        wr_ptr_d   = wr_accept ? (wr_ptr_q + 1'b1) : wr_ptr_q;
        level_d    = level_q + LW'(wr_accept) - LW'(pop);
        overflow_d = overflow_q | (wr_en & full);
`ifdef TX_QUEUE_GAP_EN
        gap_cnt_d  = gap_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    state_d    = ST_SEND;
                    enc_data_d = mem_q[rd_ptr_q];
                end
            end
            ST_SEND: begin
                if (pop) begin
`ifdef TX_QUEUE_GAP_EN
                    state_d   = ST_GAP;
                    gap_cnt_d = CW'(GAP_CYCLES - 1);
`else
                    if (level_q > LW'(1)) begin
                        enc_data_d = mem_q[rd_next];
                    end else begin
                        state_d = ST_IDLE;
                    end
`endif
                end
            end
`ifdef TX_QUEUE_GAP_EN
            // The head pointer already moved at the pop, so the next packet sits at rd_ptr_q.
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    if (!empty) begin
                        state_d    = ST_SEND;
                        enc_data_d = mem_q[rd_ptr_q];
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            enc_data_q <= '0;
            overflow_q <= 1'b0;
`ifdef TX_QUEUE_GAP_EN
            gap_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            enc_data_q <= enc_data_d;
            overflow_q <= overflow_d;
`ifdef TX_QUEUE_GAP_EN
            gap_cnt_q  <= gap_cnt_d;
`endif
        end
    end

    assign enc_data  = enc_data_q;
    assign enc_valid = (state_q == ST_SEND);
    assign level     = level_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_tx_queue.sv
// tb_tx_queue: table-driven checks of tx_queue plus a scoreboard of packets handed to the encoder.
`ifndef PACKET_SIZE
`define PACKET_SIZE 8
`endif

module tb_tx_queue;
    localparam int DEPTH      = 4;
    localparam int GAP_CYCLES = 3;
    localparam int PS         = `PACKET_SIZE;
    localparam int LW         = $clog2(DEPTH) + 1;

    typedef struct {
        logic          wrEn;
        logic [PS-1:0] wrData;
        logic          encDone;
        logic          expValid;
        logic [PS-1:0] expData;
        logic [LW-1:0] expLevel;
        logic          expFull;
        logic          expEmpty;
        logic          expOverflow;
    } vector_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [PS-1:0] wrData = '0;
    logic          wrEn = 1'b0;
    logic          encDone = 1'b0;
    logic [PS-1:0] encData;
    logic          encValid;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic          overflow;

    vector_t       table_q[$];
    logic [PS-1:0] scoreboard[$];
    logic          prevFull = 1'b0;
    int            checkCount = 0;
    int            passCount = 0;

    tx_queue #(.DEPTH(DEPTH), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clock    (clock),
        .reset    (reset),
        .wr_data  (wrData),
        .wr_en    (wrEn),
        .enc_done (encDone),
        .enc_data (encData),
        .enc_valid(encValid),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow)
    );

    always #5 clock = ~clock;

    function automatic vector_t mk(logic we, logic [PS-1:0] wd, logic done, logic v,
                                   logic [PS-1:0] d, logic [LW-1:0] l, logic f, logic e, logic o);
        vector_t r;
        r.wrEn = we; r.wrData = wd; r.encDone = done; r.expValid = v; r.expData = d;
        r.expLevel = l; r.expFull = f; r.expEmpty = e; r.expOverflow = o;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
    endtask

    // Every packet the encoder finishes must be the oldest accepted write.
    task automatic scoreboardPop();
        logic [PS-1:0] exp;
        if (scoreboard.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL sb_underflow: got packet 'h%0h, expected none", encData);
        end else begin
            exp = scoreboard.pop_front();
            checkOutput("sb_enc_data", encData, exp);
        end
    endtask

    task automatic applyStimulus(input vector_t v, input string tag);
        @(negedge clock);
        wrEn = v.wrEn; wrData = v.wrData; encDone = v.encDone;
        #2;
        if (encDone && encValid) scoreboardPop();
        if (wrEn && !prevFull) scoreboard.push_back(wrData);
        @(posedge clock);
        #1;
        prevFull = v.expFull;
        checkOutput({tag, "_valid"}, encValid, v.expValid);
        if (v.expValid) checkOutput({tag, "_data"}, encData, v.expData);
        checkOutput({tag, "_level"}, level, v.expLevel);
        checkOutput({tag, "_full"}, full, v.expFull);
        checkOutput({tag, "_empty"}, empty, v.expEmpty);
        checkOutput({tag, "_overflow"}, overflow, v.expOverflow);
    endtask

    task automatic idleInputs();
        @(negedge clock);
        wrEn = 1'b0; wrData = '0; encDone = 1'b0;
    endtask

    initial begin
        logic ovfBefore;
        int   gapCount;
        // Single write, back-to-back burst, ignored done, fill/overflow, full write+pop, write+pop.
        table_q.push_back(mk(1, 8'hB6, 0, 0, 8'h00, 1, 0, 0, 0));
        table_q.push_back(mk(0, 8'h00, 0, 1, 8'hB6, 1, 0, 0, 0));
        table_q.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 0));
        table_q.push_back(mk(1, 8'h11, 0, 0, 8'h00, 1, 0, 0, 0));
        table_q.push_back(mk(1, 8'h22, 0, 1, 8'h11, 2, 0, 0, 0));
        table_q.push_back(mk(1, 8'h33, 0, 1, 8'h11, 3, 0, 0, 0));
        table_q.push_back(mk(0, 8'h00, 1, 1, 8'h22, 2, 0, 0, 0));
        table_q.push_back(mk(0, 8'h00, 1, 1, 8'h33, 1, 0, 0, 0));
        table_q.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 0));
        table_q.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 0));
        table_q.push_back(mk(1, 8'hA1, 0, 0, 8'h00, 1, 0, 0, 0));
        table_q.push_back(mk(1, 8'hA2, 0, 1, 8'hA1, 2, 0, 0, 0));
        table_q.push_back(mk(1, 8'hA3, 0, 1, 8'hA1, 3, 0, 0, 0));
        table_q.push_back(mk(1, 8'hA4, 0, 1, 8'hA1, 4, 1, 0, 0));
        table_q.push_back(mk(1, 8'hA5, 0, 1, 8'hA1, 4, 1, 0, 1));
        table_q.push_back(mk(1, 8'hA6, 1, 1, 8'hA2, 3, 0, 0, 1));
        table_q.push_back(mk(0, 8'h00, 1, 1, 8'hA3, 2, 0, 0, 1));
        table_q.push_back(mk(0, 8'h00, 1, 1, 8'hA4, 1, 0, 0, 1));
        table_q.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 1));
        table_q.push_back(mk(1, 8'hC1, 0, 0, 8'h00, 1, 0, 0, 1));
        table_q.push_back(mk(1, 8'hC2, 0, 1, 8'hC1, 2, 0, 0, 1));
        table_q.push_back(mk(1, 8'hC3, 1, 1, 8'hC2, 2, 0, 0, 1));
        table_q.push_back(mk(0, 8'h00, 1, 1, 8'hC3, 1, 0, 0, 1));
        table_q.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 1));

        #3;
        checkOutput("rst_valid", encValid, 1'b0);
        checkOutput("rst_data", encData, '0);
        checkOutput("rst_level", level, '0);
        checkOutput("rst_empty", empty, 1'b1);
        checkOutput("rst_full", full, 1'b0);
        checkOutput("rst_overflow", overflow, 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

`ifndef TX_QUEUE_GAP_EN
        for (int i = 0; i < table_q.size(); i++) begin
            applyStimulus(table_q[i], $sformatf("v%0d", i));
        end
        ovfBefore = 1'b1;
`else
        ovfBefore = 1'b0;
        applyStimulus(mk(1, 8'h61, 0, 0, 8'h00, 1, 0, 0, 0), "g0");
        applyStimulus(mk(1, 8'h62, 0, 1, 8'h61, 2, 0, 0, 0), "g1");
        applyStimulus(mk(0, 8'h00, 1, 0, 8'h00, 1, 0, 0, 0), "g2");
        idleInputs();
        gapCount = 1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            if (encValid) break;
            gapCount++;
        end
        checkOutput("gap_cycles", gapCount, GAP_CYCLES);
        checkOutput("gap_second_data", encData, 8'h62);
        applyStimulus(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 0), "g3");
        for (int i = 0; i < GAP_CYCLES + 1; i++) applyStimulus(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0), "g4");
`endif

        // Reset in the middle of a send with three packets queued.
        applyStimulus(mk(1, 8'hD1, 0, 0, 8'h00, 1, 0, 0, ovfBefore), "r0");
        applyStimulus(mk(1, 8'hD2, 0, 1, 8'hD1, 2, 0, 0, ovfBefore), "r1");
        applyStimulus(mk(1, 8'hD3, 0, 1, 8'hD1, 3, 0, 0, ovfBefore), "r2");
        @(negedge clock);
        wrEn = 1'b0; encDone = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midrst_valid", encValid, 1'b0);
        checkOutput("midrst_level", level, '0);
        checkOutput("midrst_overflow", overflow, 1'b0);
        checkOutput("midrst_empty", empty, 1'b1);
        checkOutput("midrst_data", encData, '0);
        scoreboard.delete();
        prevFull = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        applyStimulus(mk(1, 8'hE5, 0, 0, 8'h00, 1, 0, 0, 0), "p0");
        applyStimulus(mk(0, 8'h00, 0, 1, 8'hE5, 1, 0, 0, 0), "p1");
        applyStimulus(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 0), "p2");
        idleInputs();

        checkOutput("sb_drained", scoreboard.size(), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
